// File: rtl/hamming_pkg.sv
// Shared helpers for the parametrised extended-Hamming (SECDED) codec:
// parity-bit count, power-of-two test and data-index to codeword-position map.
package hamming_pkg;

   // Smallest P with 2^P >= data_w + P + 1
   function automatic int unsigned hamming_p(input int unsigned data_w);
      int unsigned p;
      p = 0;
      for (int unsigned q = 1; q <= 7; q++) begin
         if (p == 0 && (32'd1 << q) >= data_w + q + 1) p = q;
      end
      return p;
   endfunction

   // True for Hamming positions that hold parity bits
   function automatic bit is_pow2(input int unsigned pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Codeword position of data bit idx: non-power-of-two positions from 3 upward
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned cnt;
      int unsigned pos;
      cnt = 0;
      pos = 0;
      for (int unsigned k = 3; k < 128; k++) begin
         if (!is_pow2(k)) begin
            if (cnt == idx && pos == 0) pos = k;
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_secded_syndrome.sv
// Combinational syndrome / overall-parity generator for an extended Hamming
// codeword (bit 0 = overall parity, bit k = Hamming position k).
module hamming_secded_syndrome #(
   parameter int unsigned N = 16,
   parameter int unsigned P = 4
) (
   input  logic [N-1:0] in_code,
   output logic [P-1:0] syndrome,
   output logic         overall
);

   // Syndrome is the XOR of the positions of all set bits
   always_comb begin
      syndrome = '0;
      for (int unsigned k = 1; k < N; k++) begin
         if (in_code[k]) syndrome = syndrome ^ P'(k);
      end
   end

   assign overall = ^in_code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Streaming SECDED decoder, 2-stage valid/ready pipeline.
// Optional macro HAMMING_ERR_COUNT_EN adds saturating corrected/uncorrectable
// word counters; without it the counts are tied to 0 and cnt_clr is ignored.
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter  int unsigned DATA_W = 11,
   parameter  int unsigned CNT_W  = 16,
   localparam int unsigned P      = hamming_p(DATA_W),
   localparam int unsigned N      = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [P-1:0]      out_syndrome,
   output logic              out_corrected,
   output logic              out_uncorrectable,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_count,
   output logic [CNT_W-1:0]  uncorr_count
);

   localparam int unsigned LAST_POS = N - 1;

   logic              s2_adv;
   logic [P-1:0]      in_syn;
   logic              in_ov;
   logic [DATA_W-1:0] in_data;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [P-1:0]      s1_syn;
   logic              s1_ov;

   int unsigned       syn_i;
   logic              flip_en;
   logic [DATA_W-1:0] s2_data_d;
   logic              corr_d;
   logic              uncorr_d;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   hamming_secded_syndrome #(
      .N (N),
      .P (P)
   ) u_syndrome (
      .in_code  (in_code),
      .syndrome (in_syn),
      .overall  (in_ov)
   );

   // Extract data bits from their codeword positions
   always_comb begin
      in_data = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         in_data[i] = in_code[data_pos(i)];
      end
   end

   // Stage 1: capture the word as data bits plus syndrome/parity; parity
   // positions are fully summarised by the syndrome so they are not kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_ov    <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_syn  <= in_syn;
            s1_ov   <= in_ov;
         end
      end
   end

   // Classify the word and flip the data bit addressed by the syndrome
   always_comb begin
      syn_i    = 32'(s1_syn);
      flip_en  = s1_ov && (syn_i != 0) && (syn_i <= LAST_POS);
      corr_d   = s1_ov && (syn_i <= LAST_POS);
      uncorr_d = s1_ov ? (syn_i > LAST_POS) : (syn_i != 0);
      for (int unsigned i = 0; i < DATA_W; i++) begin
         s2_data_d[i] = s1_data[i] ^ (flip_en && (syn_i == data_pos(i)));
      end
   end

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_syndrome      <= '0;
         out_corrected     <= 1'b0;
         out_uncorrectable <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data          <= s2_data_d;
            out_syndrome      <= s1_syn;
            out_corrected     <= corr_d;
            out_uncorrectable <= uncorr_d;
         end
      end
   end

`ifdef HAMMING_ERR_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic out_xfer;
   assign out_xfer = out_valid && out_ready;

   // Saturating error counters; clear has priority over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (cnt_clr) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (out_xfer) begin
         if (out_corrected && corr_count != CNT_MAX) corr_count <= corr_count + 1'b1;
         if (out_uncorrectable && uncorr_count != CNT_MAX) uncorr_count <= uncorr_count + 1'b1;
      end
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign corr_count     = '0;
   assign uncorr_count   = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder (DATA_W=11, CNT_W=2).
module tb_hamming_secded_decoder;
   import hamming_pkg::*;

   localparam int unsigned DW = 11;
   localparam int unsigned TP = hamming_p(DW);
   localparam int unsigned TN = DW + TP + 1;
   localparam int unsigned CW = 2;
`ifdef HAMMING_ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [TN-1:0] in_code = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [TP-1:0] out_syndrome;
   logic          out_corrected;
   logic          out_uncorrectable;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] corr_count;
   logic [CW-1:0] uncorr_count;

   hamming_secded_decoder #(
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_code           (in_code),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_syndrome      (out_syndrome),
      .out_corrected     (out_corrected),
      .out_uncorrectable (out_uncorrectable),
      .cnt_clr           (cnt_clr),
      .corr_count        (corr_count),
      .uncorr_count      (uncorr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [TP-1:0] s;
      logic          c;
      logic          u;
      logic          lat;
      int unsigned   acc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned cyc = 0;
   int unsigned mode = 0;      // 0: out_ready=1, 1: random, 2: out_ready=0
   int unsigned n_acc = 0;
   int unsigned exp_corr = 0;
   int unsigned exp_unc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #2;
      case (mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom % 4) != 0;
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference encoder: place data, then set parity bits so the position-XOR
   // of all ones is zero, then make total parity even.
   function automatic logic [TN-1:0] encode(input logic [DW-1:0] d);
      logic [TN-1:0] c;
      int unsigned   s;
      c = '0;
      s = 0;
      for (int unsigned i = 0; i < DW; i++) begin
         if (d[i]) begin
            c[data_pos(i)] = 1'b1;
            s = s ^ data_pos(i);
         end
      end
      for (int unsigned j = 0; j < TP; j++) begin
         if (s[j]) c[1 << j] = 1'b1;
      end
      c[0] = ^c[TN-1:1];
      return c;
   endfunction

   function automatic logic [DW-1:0] extract(input logic [TN-1:0] c);
      logic [DW-1:0] d;
      for (int unsigned i = 0; i < DW; i++) d[i] = c[data_pos(i)];
      return d;
   endfunction

   function automatic exp_t mk(input logic [DW-1:0] d, input logic [TP-1:0] s, input logic c, input logic u);
      exp_t e;
      e.d = d; e.s = s; e.c = c; e.u = u; e.lat = 1'b0; e.acc = 0;
      return e;
   endfunction

   function automatic int unsigned sat_inc(input int unsigned v);
      return (v == (1 << CW) - 1) ? v : v + 1;
   endfunction

   // Random data word with 0, 1 or 2 distinct flipped bits
   task automatic gen(output logic [TN-1:0] code, output exp_t e);
      logic [DW-1:0] d;
      int unsigned   nf, a, b;
      d = DW'($urandom);
      code = encode(d);
      nf = $urandom_range(0, 2);
      a = $urandom_range(0, TN - 1);
      b = (a + $urandom_range(1, TN - 1)) % TN;
      if (nf == 0) e = mk(d, '0, 1'b0, 1'b0);
      else if (nf == 1) begin
         code[a] = ~code[a];
         e = mk(d, TP'(a), 1'b1, 1'b0);
      end else begin
         code[a] = ~code[a];
         code[b] = ~code[b];
         e = mk(extract(code), TP'(a ^ b), 1'b0, 1'b1);
      end
   endtask

   task automatic send(input logic [TN-1:0] code, input exp_t e);
      int unsigned guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_code = code;
      #1;
      while (!in_ready && guard < 1000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         e.lat = (mode == 0);
         e.acc = cyc;
         sb.push_back(e);
         n_acc++;
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned g = 0;
      while (sb.size() != 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("drain_empty", sb.size(), 0);
      @(negedge clk);
   endtask

   // Monitor: stability while stalled, then pop-and-compare on each transfer
   initial begin : monitor
      logic           held_v;
      logic [DW+TP+2:0] held_bus;
      logic           xfer;
      exp_t           e;
      held_v = 1'b0;
      held_bus = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v = 1'b0;
         end else begin
            if (held_v)
               chk("hold_stable", {out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable}, held_bus);
            xfer = out_valid && out_ready;
            e = mk('0, '0, 1'b0, 1'b0);
            if (xfer) begin
               chk("corr_count", corr_count, exp_corr);
               chk("uncorr_count", uncorr_count, exp_unc);
               if (sb.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("out_data", out_data, e.d);
                  chk("out_syndrome", out_syndrome, e.s);
                  chk("out_corrected", out_corrected, e.c);
                  chk("out_uncorrectable", out_uncorrectable, e.u);
                  if (e.lat) chk("latency", cyc, e.acc + 2);
               end
            end
            if (CNT_EN) begin
               if (cnt_clr) begin
                  exp_corr = 0;
                  exp_unc = 0;
               end else if (xfer) begin
                  if (e.c) exp_corr = sat_inc(exp_corr);
                  if (e.u) exp_unc = sat_inc(exp_unc);
               end
            end
            held_v = out_valid && !out_ready;
            held_bus = {out_valid, out_data, out_syndrome, out_corrected, out_uncorrectable};
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      logic [TN-1:0] codes [6];
      exp_t          exps [6];
      logic [TN-1:0] c;
      exp_t          e;

      codes = '{16'h0000, 16'hFFFF, 16'hBFFF, 16'h0020, 16'h0001, 16'h0028};
      exps[0] = mk(11'h000, 4'h0, 1'b0, 1'b0);
      exps[1] = mk(11'h7FF, 4'h0, 1'b0, 1'b0);
      exps[2] = mk(11'h7FF, 4'hE, 1'b1, 1'b0);
      exps[3] = mk(11'h000, 4'h5, 1'b1, 1'b0);
      exps[4] = mk(11'h000, 4'h0, 1'b1, 1'b0);
      exps[5] = mk(11'h003, 4'h6, 1'b0, 1'b1);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_flags", {out_syndrome, out_corrected, out_uncorrectable}, 0);
      chk("rst_counts", {corr_count, uncorr_count}, 0);
      #1 rst_n = 1'b1;
      mode = 0;
      repeat (2) @(posedge clk);

      // Directed vectors, back to back
      for (int i = 0; i < 6; i++) send(codes[i], exps[i]);
      idle();
      drain();

      // Counter saturation: clear, then 5 corrected words
      @(posedge clk); #2 cnt_clr = 1'b1;
      @(posedge clk); #2 cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) send(16'h0020, mk(11'h000, 4'h5, 1'b1, 1'b0));
      idle();
      drain();
      chk("corr_saturated", corr_count, CNT_EN ? 3 : 0);

      // Clear coinciding with a corrected transfer
      @(posedge clk); #2 cnt_clr = 1'b1;
      send(16'h0001, mk(11'h000, 4'h0, 1'b1, 1'b0));
      idle();
      drain();
      @(posedge clk); #2 cnt_clr = 1'b0;
      @(negedge clk);
      chk("corr_clr_wins", corr_count, 0);

      // Backpressure: out_ready low, offer 3 words
      mode = 2;
      repeat (2) @(posedge clk);
      n_acc = 0;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               gen(c, e);
               send(c, e);
            end
            idle();
         end
         begin
            repeat (6) @(negedge clk);
            #2;
            chk("bp_accepted", n_acc, 2);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            mode = 0;
         end
      join
      drain();
      chk("bp_all_three", n_acc, 3);

      // Randomised traffic with random backpressure
      mode = 1;
      for (int i = 0; i < 300; i++) begin
         gen(c, e);
         send(c, e);
         if ($urandom_range(0, 7) == 0) idle();
      end
      idle();
      mode = 0;
      drain();

      // Reset with both stages full
      mode = 2;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         gen(c, e);
         send(c, e);
      end
      idle();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_counts", {corr_count, uncorr_count}, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      sb.delete();
      exp_corr = 0;
      exp_unc = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      mode = 0;
      repeat (2) @(posedge clk);
      gen(c, e);
      send(c, e);
      idle();
      drain();

      chk("final_scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
